d_ff_pipeline: RTL
==================

// Module: d_ff_pipeline
// PURPOSE
//   Parametrised, valid-tagged register pipeline. It extends the single D flip-flop
//   to WIDTH bits and DEPTH stages, and adds stall (en), synchronous flush and an
//   occupancy count. Used as a fixed-latency delay line / retiming stage between
//   datapath blocks, with stall and flush controls from the local controller.
// PARAMETERS
//   WIDTH        8      data width in bits (>=1)
//   DEPTH        4      number of register stages = latency in cycles (>=1)
//   RESET_VAL    0      value loaded into every data stage on reset (WIDTH bits)
//   GATE_INVALID 0      1: Q driven to RESET_VAL whenever out_valid=0; 0: Q = last-stage data
// PORTS
//   clk        in   1                      rising-edge clock
//   rst        in   1                      asynchronous reset, active-high
//   en         in   1                      1: pipeline advances; 0: all state holds (stall)
//   flush      in   1                      synchronous clear of all valid tags
//   in_valid   in   1                      D carries a valid word this cycle
//   D          in   WIDTH                  input data
//   Q          out  WIDTH                  output data (last stage)
//   out_valid  out  1                      Q carries a valid word
//   occupancy  out  clog2(DEPTH+1)         number of stages holding valid words, 0..DEPTH
// BEHAVIOUR
//   - Reset (async, rst=1): every data stage = RESET_VAL, every valid tag = 0, occupancy = 0.
//     Outputs take these values immediately, without waiting for clk. Reset mid-stream
//     discards all words in flight.
//   - Advance (en=1, flush=0) on each rising clk:
//     stage[0] <= {in_valid, D}; stage[i] <= stage[i-1] for i=1..DEPTH-1.
//     Q / out_valid come from stage[DEPTH-1]. Latency: a word sampled at edge k appears
//     at Q after edge k+DEPTH-1, i.e. DEPTH edges inclusive. No combinational D->Q path.
//   - Data registers advance regardless of in_valid. Bubbles propagate with valid=0.
//   - Stall (en=0, flush=0): all data, valid tags and occupancy hold. in_valid/D are
//     ignored; the word is dropped, and the upstream block owns retry.
//   - Flush (flush=1): on the next edge all valid tags = 0 and occupancy = 0. Data
//     registers hold. in_valid on the same cycle is dropped. flush has priority over
//     en (it takes effect even when en=0).
//   - Occupancy counter (registered, not recomputed from tags), on an advancing edge:
//     +1 if in_valid and not out_valid; -1 if out_valid and not in_valid; else unchanged.
//     Simultaneous entry and exit at DEPTH keeps DEPTH. The counter never wraps. The
//     invariant occupancy == popcount(valid tags) holds every cycle, and a bench
//     assertion checks it.
//   - GATE_INVALID=1: Q = out_valid ? stage[DEPTH-1].data : RESET_VAL (combinational mux).
//   - DEPTH=1 degenerates to a single enabled, flushable, tagged register.
// STRUCTURE
//   - Package d_ff_pkg: clog2 helper function for the occupancy width, and the stage
//     record layout {valid, data}.
//   - Sub-module d_ff_stage: one WIDTH+1-bit register with async reset to {0,RESET_VAL},
//     enable and valid-clear input. d_ff_pipeline instantiates DEPTH copies in a
//     generate loop and adds the occupancy counter and the output gating mux.
// TESTING  (WIDTH=8, DEPTH=4, RESET_VAL=8'h00 unless stated; clk period 10 ns)
//   1 Reset: rst=1 asynchronously mid-stream with 3 words in flight
//     -> Q=8'h00, out_valid=0, occupancy=0 before the next clk edge; stays so while rst=1.
//   2 Latency: in_valid=1 with D=A1,A2,A3 on three consecutive edges, en=1
//     -> Q=A1 with out_valid=1 exactly 4 edges after A1 is sampled, then A2 and A3.
//     occupancy goes 1,2,3,3 then 2,1,0.
//   3 Stall: en=0 for 3 cycles while A2 is in stage 1
//     -> Q, out_valid and occupancy frozen; after en=1, A2 and A3 emerge 3 cycles later
//     than in scenario 2, with none lost or duplicated. The word offered during the stall
//     never appears.
//   4 Flush: flush=1 together with in_valid=1, D=8'h55, and 2 words in flight
//     -> next edge out_valid=0 and occupancy=0. 8'h55 never appears with out_valid=1.
//     Repeat with en=0: same result.
//   5 Full streaming: in_valid=1 for 10 consecutive edges with D=8'h10..8'h19
//     -> occupancy reaches 4 and holds 4 while input and output are simultaneous.
//     Outputs come in order 10..19.
//   6 GATE_INVALID=1, RESET_VAL=8'hFF: alternate valid and bubble inputs
//     -> Q=8'hFF on every bubble cycle, and Q = the input word on valid cycles.

Source files
------------

// File: rtl/d_ff_pkg.sv
// Shared definitions for the valid-tagged register pipeline: width helpers and
// the {valid, data} stage record layout.
package d_ff_pkg;

    // Ceiling log2, minimum 1, so a counter of 0..value-1 always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A stage record is WIDTH+1 bits wide with the valid tag in the MSB.
    function automatic int rec_width(input int width);
        return width + 1;
    endfunction

    function automatic int valid_idx(input int width);
        return width;
    endfunction

endpackage

// File: rtl/d_ff_pipeline_if.sv
// Bus bundle between an upstream controller (master) and the tagged pipeline (slave).
interface d_ff_pipeline_if
    import d_ff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int OCC_W = clog2(DEPTH + 1);

    // Handshake: en, flush, in_valid and D are sampled on the rising clock. There is
    // no backpressure: a word offered while en=0 or flush=1 is dropped and the
    // upstream block retries. out_valid qualifies Q; occupancy counts valid stages.
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             out_valid;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output en, flush, in_valid, D,
        input  Q, out_valid, occupancy
    );

    modport slave (
        input  en, flush, in_valid, D,
        output Q, out_valid, occupancy
    );

endinterface

// File: rtl/d_ff_stage.sv
// One pipeline stage: a {valid, data} register with async reset, enable and a
// valid-clear that leaves the data bits untouched.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [rec_width(WIDTH)-1:0] rec_in,
    output logic [rec_width(WIDTH)-1:0] rec_out
);
    localparam int VI = valid_idx(WIDTH);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Clear wins over enable, and only touches the tag.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = rec_in[WIDTH-1:0];
            valid_d = rec_in[VI];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rec_out = {valid_q, data_q};

endmodule

// File: rtl/d_ff_pipeline.sv
// Fixed-latency, valid-tagged delay line of DEPTH stages with stall, flush and a
// registered occupancy count.
module d_ff_pipeline
    import d_ff_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               GATE_INVALID = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    d_ff_pipeline_if.slave       bus
);
    localparam int RW    = rec_width(WIDTH);
    localparam int VI    = valid_idx(WIDTH);
    localparam int OCC_W = clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [RW-1:0] rec_out [DEPTH];
    logic          adv;
    logic          last_valid;
    logic [WIDTH-1:0] last_data;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_q;

    assign adv = bus.en && !bus.flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [RW-1:0] stage_in;
        if (gi == 0) begin : g_head
            assign stage_in = {bus.in_valid, bus.D};
        end else begin : g_body
            assign stage_in = rec_out[gi-1];
        end

        d_ff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .clr     (bus.flush),
            .rec_in  (stage_in),
            .rec_out (rec_out[gi])
        );
    end

    assign last_valid = rec_out[DEPTH-1][VI];
    assign last_data  = rec_out[DEPTH-1][WIDTH-1:0];

    // Counter tracks entries and exits independently of the tags; the bounds
    // guards keep it from wrapping even if the two ever disagreed.
    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (bus.en) begin
            if (bus.in_valid && !last_valid && occ_q != OCC_MAX) begin
                occ_d = occ_q + 1'b1;
            end else if (!bus.in_valid && last_valid && occ_q != '0) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.out_valid = last_valid;
    assign bus.occupancy = occ_q;
    assign bus.Q         = (GATE_INVALID && !last_valid) ? RESET_VAL : last_data;

endmodule
